// File: rtl/counter_job_scheduler_if.sv
// Job request and result channels between the requesters and counter_job_scheduler.
// The scheduler takes the slave side; requester logic takes the master side.
interface counter_job_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_start;
  logic [8*N_REQ-1:0] req_len;
  logic [N_REQ-1:0]   req_ready;
  logic               done_valid;
  logic [IDW-1:0]     done_id;
  logic [7:0]         done_val;
  logic               done_ready;

  modport master (
    output req_valid, req_start, req_len, done_ready,
    input  req_ready, done_valid, done_id, done_val
  );

  modport slave (
    input  req_valid, req_start, req_len, done_ready,
    output req_ready, done_valid, done_id, done_val
  );
endinterface

// File: rtl/counter_job_scheduler.sv
// Round-robin scheduler that time-shares one 8-bit counter among N_REQ requesters.
// It loads the counter, lets it free-run len cycles, reads it back and returns the result.
module counter_job_scheduler #(
  parameter int N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_job_scheduler_if.slave  jobs,
  output logic                    busy,
  output logic                    ctr_rst,
  output logic                    ctr_load_e,
  output logic                    ctr_out_e,
  output logic [7:0]              ctr_load_val,
  input  logic [7:0]              ctr_data
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, RESP} state_t;

  state_t             state, state_next;
  logic [IDW-1:0]     ptr, ptr_next;
  logic [7:0]         rem, rem_next;
  logic [7:0]         start_q, start_next;
  logic [7:0]         len_q, len_next;
  logic [IDW-1:0]     id_q, id_next;
  logic [7:0]         done_val_q, done_val_next;
  logic [IDW-1:0]     done_id_q, done_id_next;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               grant_any;
  logic [IDW-1:0]     offset;
  logic [IDW:0]       wsum;
  logic [IDW-1:0]     winner;
  logic [7:0]         start_sel;
  logic [7:0]         len_sel;

  // Rotate the valid vector so bit 0 is the requester at ptr; the lowest set bit wins.
  assign req_dbl = {jobs.req_valid, jobs.req_valid} >> ptr;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    grant_any = 1'b0;
    offset    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_any = 1'b1;
        offset    = IDW'(k);
      end
    end
    wsum = {1'b0, ptr} + {1'b0, offset};
    if (wsum >= (IDW+1)'(N_REQ))
      wsum = wsum - (IDW+1)'(N_REQ);
    winner = wsum[IDW-1:0];

    start_sel = '0;
    len_sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == IDW'(k)) begin
        start_sel = jobs.req_start[8*k +: 8];
        len_sel   = jobs.req_len[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      rem        <= '0;
      start_q    <= '0;
      len_q      <= '0;
      id_q       <= '0;
      done_val_q <= '0;
      done_id_q  <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      rem        <= rem_next;
      start_q    <= start_next;
      len_q      <= len_next;
      id_q       <= id_next;
      done_val_q <= done_val_next;
      done_id_q  <= done_id_next;
    end
  end

  // Grants and the done strobe are masked during reset so nothing handshakes on a reset edge.
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    rem_next      = rem;
    start_next    = start_q;
    len_next      = len_q;
    id_next       = id_q;
    done_val_next = done_val_q;
    done_id_next  = done_id_q;
    jobs.req_ready  = '0;
    jobs.done_valid = 1'b0;
    ctr_load_e      = 1'b0;
    ctr_out_e       = 1'b0;
    ctr_load_val    = '0;
    busy            = (state != IDLE);

    case (state)
      IDLE: begin
        if (grant_any) begin
          if (!rst)
            jobs.req_ready[winner] = 1'b1;
          start_next = start_sel;
          len_next   = len_sel;
          id_next    = winner;
          ptr_next   = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        ctr_load_e   = 1'b1;
        ctr_load_val = start_q;
        if (len_q == 8'd0) begin
          state_next = READ;
        end else begin
          rem_next   = len_q - 8'd1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (rem == 8'd0)
          state_next = READ;
        else
          rem_next = rem - 8'd1;
      end
      READ: begin
        ctr_out_e     = 1'b1;
        done_val_next = ctr_data;
        done_id_next  = id_q;
        state_next    = RESP;
      end
      RESP: begin
        jobs.done_valid = !rst;
        if (jobs.done_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ctr_rst       = rst;
  assign jobs.done_val = done_val_q;
  assign jobs.done_id  = done_id_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(jobs.req_ready));
  a_bus_exclusive: assert property (@(posedge clk) disable iff (rst) !(ctr_load_e && ctr_out_e));
endmodule

// File: tb/tb_counter_job_scheduler.sv
// Directed bench for counter_job_scheduler with a behavioural counter_8_bit on the shared bus.
module tb_counter_job_scheduler;
  localparam int N_REQ = 4;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       ctr_rst;
  logic       ctr_load_e;
  logic       ctr_out_e;
  logic [7:0] ctr_load_val;
  logic [7:0] cnt;
  wire  [7:0] ctr_bus;

  int n_compared;
  int n_mismatched;

  counter_job_scheduler_if #(.N_REQ(N_REQ)) jobs ();

  counter_job_scheduler #(.N_REQ(N_REQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .jobs         (jobs),
    .busy         (busy),
    .ctr_rst      (ctr_rst),
    .ctr_load_e   (ctr_load_e),
    .ctr_out_e    (ctr_out_e),
    .ctr_load_val (ctr_load_val),
    .ctr_data     (ctr_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running counter: load wins over increment, and the bus is released unless out_e.
  always @(posedge clk) begin
    if (ctr_rst)
      cnt <= 8'd0;
    else if (ctr_load_e)
      cnt <= ctr_load_val;
    else
      cnt <= cnt + 8'd1;
  end
  assign ctr_bus = ctr_out_e ? cnt : 8'bz;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] start, input logic [7:0] len);
    jobs.req_start[8*id +: 8] = start;
    jobs.req_len[8*id +: 8]   = len;
    jobs.req_valid[id]        = 1'b1;
  endtask

  // Waits for the grant, then follows the job cycle by cycle until done_valid rises.
  task automatic runJob(input int id, input int len, input logic [7:0] exp_val,
                        input bit keep, input string tag);
    int n;
    int lat;
    int n_load;
    int n_run;
    int n_out;
    #1;
    n = 0;
    while (jobs.req_ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_grant"}, 32'(jobs.req_ready), 32'(1) << id);
    lat = 0;
    n_load = 0;
    n_run = 0;
    n_out = 0;
    do begin
      @(negedge clk);
      if (lat == 0 && !keep)
        jobs.req_valid[id] = 1'b0;
      #1;
      lat++;
      n_load += int'(ctr_load_e);
      n_out  += int'(ctr_out_e);
      if (busy && !ctr_load_e && !ctr_out_e && !jobs.done_valid)
        n_run++;
    end while (!jobs.done_valid && lat < len + 20);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(len + 3));
    checkOutput({tag, "_load_cycles"}, 32'(n_load), 32'd1);
    checkOutput({tag, "_run_cycles"}, 32'(n_run), 32'(len));
    checkOutput({tag, "_read_cycles"}, 32'(n_out), 32'd1);
    checkOutput({tag, "_done_id"}, 32'(jobs.done_id), 32'(id));
    checkOutput({tag, "_done_val"}, 32'(jobs.done_val), 32'(exp_val));
  endtask

  // Cycle-by-cycle invariants that hold across every job.
  always @(negedge clk) begin
    #2;
    checkOutput("bus_exclusive", 32'(ctr_load_e & ctr_out_e), 32'd0);
    checkOutput("ready_onehot0", 32'($countones(jobs.req_ready) <= 1), 32'd1);
    checkOutput("ready_only_idle", 32'((|jobs.req_ready) & busy), 32'd0);
    checkOutput("ctr_rst_follows", 32'(ctr_rst), 32'(rst));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared      = 0;
    n_mismatched    = 0;
    rst             = 1'b1;
    jobs.req_valid  = '0;
    jobs.req_start  = '0;
    jobs.req_len    = '0;
    jobs.done_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done_valid", 32'(jobs.done_valid), 32'd0);
    checkOutput("reset_done_val", 32'(jobs.done_val), 32'd0);
    checkOutput("reset_done_id", 32'(jobs.done_id), 32'd0);
    checkOutput("reset_ready", 32'(jobs.req_ready), 32'd0);
    checkOutput("reset_ctr_rst", 32'(ctr_rst), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single job: 0x10 + 5.
    applyStimulus(0, 8'h10, 8'd5);
    runJob(0, 5, 8'h15, 1'b0, "single");
    @(negedge clk);
    #1;
    checkOutput("single_idle_after", 32'(busy), 32'd0);
    checkOutput("single_val_hold", 32'(jobs.done_val), 32'h15);

    // Zero length, then wrap-around through 0xFF.
    applyStimulus(1, 8'hAB, 8'd0);
    runJob(1, 0, 8'hAB, 1'b0, "zero_len");
    @(negedge clk);
    applyStimulus(2, 8'hF0, 8'h20);
    runJob(2, 32, 8'h10, 1'b0, "wrap");
    @(negedge clk);

    // Round-robin with everyone held valid; ptr is 3 after the wrap job, so start at 0 via 3.
    for (int i = 0; i < N_REQ; i++)
      applyStimulus(i, 8'(i), 8'd1);
    runJob(3, 1, 8'h04, 1'b1, "rr_pre");
    runJob(0, 1, 8'h01, 1'b1, "rr0");
    runJob(1, 1, 8'h02, 1'b1, "rr1");
    runJob(2, 1, 8'h03, 1'b1, "rr2");
    runJob(3, 1, 8'h04, 1'b1, "rr3");
    runJob(0, 1, 8'h01, 1'b1, "rr0b");
    jobs.req_valid = '0;
    @(negedge clk);

    // Back-pressure: result must hold and nothing new is accepted while stalled.
    jobs.done_ready = 1'b0;
    applyStimulus(2, 8'h33, 8'd3);
    runJob(2, 3, 8'h36, 1'b0, "bp");
    applyStimulus(1, 8'h01, 8'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", 32'(jobs.done_valid), 32'd1);
      checkOutput("bp_id", 32'(jobs.done_id), 32'd2);
      checkOutput("bp_val", 32'(jobs.done_val), 32'h36);
      checkOutput("bp_no_grant", 32'(jobs.req_ready), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
    end
    jobs.done_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp_idle_after", 32'(busy), 32'd0);
    checkOutput("bp_next_done_valid", 32'(jobs.done_valid), 32'd0);
    runJob(1, 2, 8'h03, 1'b0, "bp_next");
    @(negedge clk);

    // Reset in the middle of a long job; ptr must return to 0.
    applyStimulus(3, 8'h00, 8'd50);
    #1;
    checkOutput("abort_grant", 32'(jobs.req_ready), 32'h8);
    @(negedge clk);
    jobs.req_valid[3] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("abort_in_run", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_rst_done_valid", 32'(jobs.done_valid), 32'd0);
    checkOutput("abort_rst_ctr_rst", 32'(ctr_rst), 32'd1);
    @(negedge clk);
    applyStimulus(0, 8'h20, 8'd4);
    applyStimulus(1, 8'h40, 8'd0);
    #1;
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);
    checkOutput("abort_no_ready", 32'(jobs.req_ready), 32'd0);
    checkOutput("abort_done_valid", 32'(jobs.done_valid), 32'd0);
    checkOutput("abort_done_val", 32'(jobs.done_val), 32'd0);
    checkOutput("abort_done_id", 32'(jobs.done_id), 32'd0);
    checkOutput("abort_load_e", 32'(ctr_load_e), 32'd0);
    checkOutput("abort_out_e", 32'(ctr_out_e), 32'd0);
    checkOutput("abort_load_val", 32'(ctr_load_val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runJob(0, 4, 8'h24, 1'b0, "post_rst0");
    runJob(1, 0, 8'h40, 1'b0, "post_rst1");
    @(negedge clk);
    #1;
    checkOutput("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/counter_job_scheduler.md
# counter_job_scheduler

Round-robin scheduler that shares one `counter_8_bit` instance between N_REQ requesters. Each requester submits a job (start value, increment count). The scheduler loads the counter, lets it free-run for exactly the requested number of cycles, then enables its tri-state output for one cycle and captures the result. It returns the result with the requester ID over a valid/ready response channel. It sits between the requester logic and the counter, and drives all of the counter's control pins.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8); ID width IDW = clog2(N_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  per-requester job valid.
- req_start  in  8*N_REQ  start value; slice i = [8i+7:8i].
- req_len  in  8*N_REQ  increments to apply (0..255); slice i = [8i+7:8i].
- req_ready  out  N_REQ  one-hot accept.
- done_valid  out  1  result available.
- done_id  out  IDW  requester ID of result.
- done_val  out  8  captured counter value.
- done_ready  in  1  result consumed.
- busy  out  1  high in every state except IDLE.
- ctr_rst  out  1  to counter rst.
- ctr_load_e  out  1  to counter load_e.
- ctr_out_e  out  1  to counter out_e.
- ctr_load_val  out  8  to counter load_val.
- ctr_data  in  8  from counter out_data (tri-state bus).

## Operation

- States: IDLE, LOAD, RUN, READ, RESP.
- **IDLE**
  - If any req_valid is high, select a winner round-robin, searching from pointer `ptr` upward with wrap.
  - Assert req_ready[winner] combinationally in this cycle only.
  - Latch start, len and ID.
  - Set ptr = (winner+1) mod N_REQ.
  - Go to LOAD.
- **LOAD**
  - ctr_load_e = 1, ctr_load_val = latched start.
  - If len == 0, go to READ. Otherwise set rem = len-1 and go to RUN.
- **RUN**
  - All counter controls low; the counter increments every cycle.
  - If rem == 0, go to READ; else rem = rem-1.
  - Total RUN cycles = len.
- **READ**
  - ctr_out_e = 1.
  - At the closing edge, done_val ← ctr_data and done_id ← latched ID. Go to RESP.
- **RESP**
  - done_valid = 1.
  - On done_valid & done_ready, go to IDLE.
- Handshake rules:
  - Requesters hold req_valid, req_start and req_len stable until they see req_ready.
  - A requester may deassert req_valid before it is granted.
  - A requester with no valid request is never granted.
- Counter control:
  - ctr_load_e and ctr_out_e are Moore decodes of state.
  - ctr_out_e is high only in READ, so the shared bus is tri-stated in all other states.
  - ctr_rst = rst, combinational passthrough.
- Arithmetic: result = (start + len) mod 256. Wrap-around comes from the counter itself; the scheduler performs no addition.
- done_val and done_id hold their value until the next capture.
- Reset values: state IDLE, ptr 0, rem 0, latched start/len/ID 0. All outputs 0 except ctr_rst, which follows rst.
- Reset mid-operation:
  - Any state returns to IDLE at the reset edge and the job in flight is discarded.
  - No req_ready or done_valid is asserted while rst is high.
  - The counter is reset through ctr_rst.

## Timing

- Handshake edge E0 (end of the IDLE cycle). The LOAD cycle follows, and the counter equals start after edge E1.
- Capture edge is E(len+2). done_valid first goes high in the cycle after E(len+2).
- With done_ready held high, one job takes len+4 cycles: IDLE, LOAD, len×RUN, READ, RESP.
- A new grant can occur in the first IDLE cycle after RESP completes.
- req_ready is never asserted outside IDLE. At most one bit of req_ready is high in any cycle.
- If done_ready is low, RESP stalls indefinitely. No new job is accepted during the stall, and busy stays high.

## Test plan

- **Single job:** req0 with start=0x10, len=5 → req_ready[0] for 1 cycle; ctr_load_e for 1 cycle; 5 RUN cycles; ctr_out_e for 1 cycle; done_valid with done_id=0, done_val=0x15, rising 7 edges after E0.
- **Zero length and wrap:** len=0, start=0xAB → LOAD goes straight to READ and done_val=0xAB. Separately, start=0xF0, len=0x20 → done_val=0x10.
- **Round-robin:** req0..3 held valid continuously, each with start=i, len=1 → grants in order 0,1,2,3,0; each done_val = i+1.
- **Back-pressure:** done_ready low for 10 cycles → done_valid, done_id and done_val stay stable; no req_ready; busy=1. After the done_valid & done_ready handshake → IDLE in the next cycle.
- **Reset mid-RUN:** rst asserted during RUN of a len=50 job → next cycle is IDLE with all outputs 0 and ptr=0; no done_valid for the aborted job; the next job from req0 completes correctly.
- **Bus isolation:** across all jobs → ctr_out_e high only in READ cycles, and ctr_load_e never high in the same cycle as ctr_out_e.
